// File: rtl/axi_read_slave_mem.sv
// AXI3 read-channel slave backed by a local word memory with a backdoor write port.
// Requests are queued in a small FIFO and replayed as FIXED/INCR/WRAP bursts on R.
module axi_read_slave_mem #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LOG2 = 10,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [ID_W-1:0]                           arid,
    input  logic [ADDR_W-1:0]                         araddr,
    input  logic [3:0]                                arlen,
    input  logic [2:0]                                arsize,
    input  logic [1:0]                                arburst,
    input  logic [1:0]                                arlock,
    input  logic [3:0]                                arcache,
    input  logic [2:0]                                arprot,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [ID_W-1:0]                           rid,
    output logic [DATA_W-1:0]                         rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    input  logic                                      mem_we,
    input  logic [MEM_LOG2-$clog2(DATA_W/8)-1:0]      mem_waddr,
    input  logic [DATA_W-1:0]                         mem_wdata
);
    localparam int unsigned STRB   = DATA_W / 8;
    localparam int unsigned SLOG   = $clog2(STRB);
    localparam int unsigned WIDX_W = MEM_LOG2 - SLOG;
    localparam int unsigned WORDS  = 2 ** WIDX_W;
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;
    } ar_entry_t;

    typedef enum logic {IDLE, BURST} state_t;

    logic [DATA_W-1:0] mem_q [WORDS];
    ar_entry_t         fifo_q [QDEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              arready_q;

    state_t            state_q;
    ar_entry_t         cur_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        beat_q;
    logic              rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    ar_entry_t         ar_entry_c, head_c;
    logic              ar_hs_c, pop_c, adv_c, empty_c, wrap_len_ok_c;
    logic [ADDR_W-1:0] ar_step_c, next_addr_c, sel_addr_c;
    logic              sel_err_c;
    logic [DATA_W-1:0] sel_data_c;

    wire unused_ok = ^{arlock, arcache, arprot, cur_q.id, cur_q.addr};

    // Beat-to-beat address sequencing for the three legal burst types.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [3:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] step, mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b01:   return (a & ~(step - ADDR_W'(1))) + step;
            2'b10:   return (a & ~mask) + ((a + step) & mask);
            default: return a;
        endcase
    endfunction

    always_comb begin
        ar_step_c     = ADDR_W'(1) << arsize;
        wrap_len_ok_c = (arlen == 4'd1) || (arlen == 4'd3) || (arlen == 4'd7) || (arlen == 4'd15);
        ar_entry_c    = {arid, araddr, arlen, arsize, arburst, 1'b0};
        ar_entry_c.err = (arburst == 2'b11) || (arsize > 3'(SLOG)) ||
                         ((arburst == 2'b10) &&
                          (((araddr & (ar_step_c - ADDR_W'(1))) != '0) || !wrap_len_ok_c));

        empty_c = (count_q == '0);
        head_c  = fifo_q[rptr_q];
        ar_hs_c = arvalid && arready_q;
        adv_c   = (state_q == BURST) && rvalid_q && rready;
        pop_c   = !empty_c && ((state_q == IDLE) || (adv_c && rlast_q));

        count_d = count_q;
        if (ar_hs_c && !pop_c) count_d = count_q + CNT_W'(1);
        else if (!ar_hs_c && pop_c) count_d = count_q - CNT_W'(1);

        // Address and data of the beat that will be on R next cycle.
        next_addr_c = next_addr(addr_q, cur_q.len, cur_q.size, cur_q.burst);
        sel_addr_c  = pop_c ? head_c.addr : (adv_c ? next_addr_c : addr_q);
        sel_err_c   = (pop_c ? head_c.err : cur_q.err) || (sel_addr_c[ADDR_W-1:MEM_LOG2] != '0);
        sel_data_c  = sel_err_c ? '0 : mem_q[sel_addr_c[MEM_LOG2-1:SLOG]];
    end

    always_ff @(posedge aclk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge aclk) begin
        if (ar_hs_c) fifo_q[wptr_q] <= ar_entry_c;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            arready_q <= 1'b0;
        end else begin
            if (ar_hs_c) wptr_q <= (wptr_q == PTR_W'(QDEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            if (pop_c)   rptr_q <= (rptr_q == PTR_W'(QDEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            count_q   <= count_d;
            arready_q <= (count_d != CNT_W'(QDEPTH));
        end
    end

    // R channel FSM; a pop always loads the first beat of the popped burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else if (pop_c) begin
            state_q  <= BURST;
            cur_q    <= head_c;
            addr_q   <= sel_addr_c;
            beat_q   <= '0;
            rvalid_q <= 1'b1;
            rlast_q  <= (head_c.len == 4'd0);
            rid_q    <= head_c.id;
            rdata_q  <= sel_data_c;
            rresp_q  <= sel_err_c ? 2'b10 : 2'b00;
        end else if (adv_c && rlast_q) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else if (adv_c) begin
            addr_q   <= sel_addr_c;
            beat_q   <= beat_q + 4'd1;
            rlast_q  <= ((beat_q + 4'd1) == cur_q.len);
            rdata_q  <= sel_data_c;
            rresp_q  <= sel_err_c ? 2'b10 : 2'b00;
        end else if (state_q == BURST) begin
            rdata_q  <= sel_data_c;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed bench for axi_read_slave_mem: stimulus pushes expected beats, a monitor checks R.
module tb_axi_read_slave_mem;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic [1:0]  arlock = '0;
    logic [3:0]  arcache = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b1;
    logic        mem_we = 1'b0;
    logic [7:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    axi_read_slave_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int hs_count = 0;
    logic chk_nobubble = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        beat_t b;
        b.id = id; b.data = data; b.resp = resp; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("ar_accept", arready, 1'b1);
        @(posedge aclk);
        #1 arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge aclk); #1;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge aclk); #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        @(posedge aclk); #1;
    endtask

    // Monitor: scoreboard compare, stall stability and no-bubble checks.
    logic        stall_prev = 1'b0, last_hs_prev = 1'b0;
    logic [3:0]  s_id;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_rvalid", rvalid, 1'b1);
                check("stall_rid", rid, s_id);
                check("stall_rdata", rdata, s_data);
                check("stall_rresp", rresp, s_resp);
                check("stall_rlast", rlast, s_last);
            end
            if (chk_nobubble && last_hs_prev && exp_q.size() != 0)
                check("no_bubble", rvalid, 1'b1);
            last_hs_prev = 1'b0;
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", rvalid, 1'b0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("rid", rid, e.id);
                    check("rdata", rdata, e.data);
                    check("rresp", rresp, e.resp);
                    check("rlast", rlast, e.last);
                end
                hs_count++;
                last_hs_prev = rlast;
            end
            stall_prev = rvalid && !rready;
            s_id = rid; s_data = rdata; s_resp = rresp; s_last = rlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        // Preload mem[i] = i while held in reset.
        for (int i = 0; i < 256; i++) begin
            @(posedge aclk); #1;
            mem_we = 1'b1; mem_waddr = 8'(i); mem_wdata = 32'(i);
        end
        @(posedge aclk); #1 mem_we = 1'b0;
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rid", rid, 4'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rresp", rresp, 2'd0);
        @(negedge aclk) aresetn = 1'b1;
        #1 check("arready_before_edge", arready, 1'b0);
        @(posedge aclk); #1 check("arready_after_release", arready, 1'b1);

        // INCR 0x10 x4, with first-beat latency.
        for (int i = 0; i < 4; i++) push_exp(4'd1, 32'(4 + i), 2'b00, i == 3);
        send_ar(4'd1, 32'h10, 4'd3, 3'd2, 2'b01);
        check("latency_edge_n", rvalid, 1'b0);
        @(posedge aclk); #1 check("latency_edge_n1", rvalid, 1'b1);
        wait_drain("incr_drain");

        // WRAP 0x18 x4: 0x18, 0x1C, 0x10, 0x14.
        push_exp(4'd2, 32'd6, 2'b00, 1'b0);
        push_exp(4'd2, 32'd7, 2'b00, 1'b0);
        push_exp(4'd2, 32'd4, 2'b00, 1'b0);
        push_exp(4'd2, 32'd5, 2'b00, 1'b1);
        send_ar(4'd2, 32'h18, 4'd3, 3'd2, 2'b10);
        wait_drain("wrap_drain");

        // WRAP with illegal length: all beats SLVERR.
        for (int i = 0; i < 3; i++) push_exp(4'd3, 32'd0, 2'b10, i == 2);
        send_ar(4'd3, 32'h10, 4'd2, 3'd2, 2'b10);
        wait_drain("wrap_err_drain");

        // INCR crossing the top of memory.
        push_exp(4'd4, 32'd254, 2'b00, 1'b0);
        push_exp(4'd4, 32'd255, 2'b00, 1'b0);
        push_exp(4'd4, 32'd0, 2'b10, 1'b0);
        push_exp(4'd4, 32'd0, 2'b10, 1'b1);
        send_ar(4'd4, 32'h3F8, 4'd3, 3'd2, 2'b01);
        wait_drain("oob_drain");

        // Reserved burst type and oversize beat.
        push_exp(4'd8, 32'd0, 2'b10, 1'b1);
        send_ar(4'd8, 32'h0, 4'd0, 3'd2, 2'b11);
        push_exp(4'd9, 32'd0, 2'b10, 1'b0);
        push_exp(4'd9, 32'd0, 2'b10, 1'b1);
        send_ar(4'd9, 32'h0, 4'd1, 3'd3, 2'b01);
        wait_drain("misc_err_drain");

        // Queue full under backpressure, then release with no bubbles.
        rready = 1'b0;
        push_exp(4'd5, 32'd0, 2'b00, 1'b0);
        push_exp(4'd5, 32'd1, 2'b00, 1'b1);
        send_ar(4'd5, 32'h0, 4'd1, 3'd2, 2'b01);
        push_exp(4'd6, 32'd8, 2'b00, 1'b0);
        push_exp(4'd6, 32'd8, 2'b00, 1'b1);
        send_ar(4'd6, 32'h20, 4'd1, 3'd2, 2'b00);
        push_exp(4'd7, 32'd16, 2'b00, 1'b1);
        send_ar(4'd7, 32'h40, 4'd0, 3'd2, 2'b01);
        repeat (3) @(posedge aclk);
        #1;
        check("full_arready", arready, 1'b0);
        check("full_rvalid", rvalid, 1'b1);
        check("full_rid", rid, 4'd5);
        check("full_rdata", rdata, 32'd0);
        chk_nobubble = 1'b1;
        rready = 1'b1;
        wait_drain("queue_drain");
        chk_nobubble = 1'b0;

        // FIXED 0x8 x8, reset after the third beat.
        for (int i = 0; i < 8; i++) push_exp(4'd10, 32'd2, 2'b00, i == 7);
        base = hs_count;
        send_ar(4'd10, 32'h8, 4'd7, 3'd2, 2'b00);
        n = 0;
        while (hs_count < base + 3 && n < 100) begin
            @(negedge aclk); #1;
            n++;
        end
        check("fixed_three_beats", 32'(hs_count - base), 32'd3);
        @(posedge aclk); #1 aresetn = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_rlast", rlast, 1'b0);
        check("midrst_arready", arready, 1'b0);
        check("midrst_pending", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        repeat (3) @(posedge aclk);
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1 check("midrst_arready_release", arready, 1'b1);
        n = 0;
        repeat (10) begin
            @(negedge aclk);
            if (rvalid) n++;
        end
        check("no_beats_after_reset", 32'(n), 32'd0);

        push_exp(4'd11, 32'd3, 2'b00, 1'b1);
        @(posedge aclk); #1;
        send_ar(4'd11, 32'hC, 4'd0, 3'd2, 2'b01);
        wait_drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
